// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: function codes,
// controller states and default datapath widths.
package alu_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_SHAMT_W = 5;
    localparam int FUNC_W      = 6;

    localparam logic [FUNC_W-1:0] FN_ADD = 6'd0;
    localparam logic [FUNC_W-1:0] FN_SUB = 6'd1;
    localparam logic [FUNC_W-1:0] FN_AND = 6'd2;
    localparam logic [FUNC_W-1:0] FN_OR  = 6'd3;
    localparam logic [FUNC_W-1:0] FN_XOR = 6'd4;
    localparam logic [FUNC_W-1:0] FN_NOT = 6'd5;
    localparam logic [FUNC_W-1:0] FN_SLA = 6'd6;
    localparam logic [FUNC_W-1:0] FN_SRA = 6'd7;
    localparam logic [FUNC_W-1:0] FN_SRL = 6'd8;
    localparam logic [FUNC_W-1:0] FN_MAX = 6'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response channels between a client and the ALU operation sequencer.
interface alu_op_sequencer_if
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic              req_valid;
    logic              req_ready;
    logic [FUNC_W-1:0] req_func;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_res;
    logic              rsp_err;

    modport master (
        output req_valid, req_func, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_res, rsp_err
    );

    modport slave (
        input  req_valid, req_func, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_res, rsp_err
    );

endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller in front of a one-bit-per-pass combinational ALU;
// shifts are iterated by feeding the ALU result back as operand a.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    alu_op_sequencer_if.slave  bus,
    output logic               o_busy,
    output logic [FUNC_W-1:0]  o_alu_func,
    output logic [DATA_W-1:0]  o_alu_a,
    output logic [DATA_W-1:0]  o_alu_b,
    input  logic [DATA_W-1:0]  i_alu_res
);

    state_t              r_state;
    logic [SHAMT_W-1:0]  r_count;
    logic                r_busy;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_res;
    logic                r_rsp_err;
    logic [FUNC_W-1:0]   r_alu_func;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [SHAMT_W-1:0]  w_shamt;

    assign w_shamt = bus.req_b[SHAMT_W-1:0];

    // The shift accumulator is r_alu_a itself: it already holds the operand
    // presented to the ALU, so each pass just loads the result back into it.
    // NOTE: every register here is assigned with <= so all updates in a cycle
    // see the pre-edge values, and reset is sampled only at the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_res   <= '0;
            r_rsp_err   <= 1'b0;
            r_alu_func  <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_busy <= 1'b1;
                        if (bus.req_func <= FN_NOT) begin
                            r_state    <= EXEC;
                            r_alu_func <= bus.req_func;
                            r_alu_a    <= bus.req_a;
                            r_alu_b    <= bus.req_b;
                        end else if (bus.req_func <= FN_MAX && w_shamt != '0) begin
                            r_state    <= SHIFT;
                            r_count    <= w_shamt;
                            r_alu_func <= bus.req_func;
                            r_alu_a    <= bus.req_a;
                            r_alu_b    <= DATA_W'(1);
                        end else begin
                            // Zero-length shift passes a through; unknown codes flag an error.
                            r_state     <= DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= (bus.req_func > FN_MAX);
                            r_rsp_res   <= (bus.req_func > FN_MAX) ? '0 : bus.req_a;
                        end
                    end
                end
                EXEC: begin
                    r_state     <= DONE;
                    r_rsp_valid <= 1'b1;
                    r_rsp_res   <= i_alu_res;
                    r_rsp_err   <= 1'b0;
                    r_alu_func  <= '0;
                    r_alu_a     <= '0;
                    r_alu_b     <= '0;
                end
                SHIFT: begin
                    r_count <= r_count - SHAMT_W'(1);
                    if (r_count == SHAMT_W'(1)) begin
                        r_state     <= DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_res   <= i_alu_res;
                        r_rsp_err   <= 1'b0;
                        r_alu_func  <= '0;
                        r_alu_a     <= '0;
                        r_alu_b     <= '0;
                    end else begin
                        r_alu_a <= i_alu_res;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = (r_state == IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_res   = r_rsp_res;
    assign bus.rsp_err   = r_rsp_err;
    assign o_busy        = r_busy;
    assign o_alu_func    = r_alu_func;
    assign o_alu_a       = r_alu_a;
    assign o_alu_b       = r_alu_b;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller in front of the 32-bit combinational ALU.
- Accepts one operation at a time over a valid/ready request channel and drives the ALU's func/a/b inputs.
- Logic and arithmetic ops complete in a single ALU pass.
- Shift ops (ALU shifts by one bit per pass) are repeated b[4:0] times by feeding the result back as operand a.
- The result is returned on a valid/ready response channel.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU.
- SHAMT_W, 5, number of low bits of req_b used as the shift amount.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_func  input  6  ALU function code: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not, 6 sla, 7 sra, 8 srl
- req_a  input  DATA_W  operand a
- req_b  input  DATA_W  operand b; for shifts, the amount is req_b[SHAMT_W-1:0]
- rsp_valid  output  1  result present
- rsp_ready  input  1  consumer accepts result
- rsp_res  output  DATA_W  result
- rsp_err  output  1  request had an unsupported func (>8)
- busy  output  1  high in any state other than IDLE
- alu_func  output  6  to ALU func
- alu_a  output  DATA_W  to ALU a
- alu_b  output  DATA_W  to ALU b
- alu_res  input  DATA_W  from ALU res

Behaviour:
- States: IDLE, EXEC, SHIFT, DONE.
- Reset (rst=1 at a clk edge) forces IDLE; any in-flight op is discarded. All registered outputs reset to 0: rsp_valid, rsp_res, rsp_err, busy, alu_func, alu_a, alu_b, and the internal count.
- IDLE:
  - req_ready=1; ALU inputs driven to 0.
  - Accept on req_valid & req_ready (cycle T): latch func, a, b.
  - func 0..5 -> EXEC.
  - func 6..8 with shamt=0 -> DONE with rsp_res=a, rsp_err=0.
  - func 6..8 with shamt>0 -> SHIFT, with count=shamt and acc=a.
  - func 9..63 -> DONE with rsp_res=0, rsp_err=1.
- EXEC:
  - Drive alu_func=func, alu_a=a, alu_b=b.
  - Capture alu_res into rsp_res at the cycle end, then go to DONE.
  - rsp_valid first high at T+2.
- SHIFT:
  - Drive alu_func=func, alu_a=acc, alu_b=1 (ALU shifts only when b[0]=1).
  - Each cycle: acc<=alu_res, count<=count-1.
  - When count==1, load rsp_res<=alu_res and go to DONE.
  - Shift by N: rsp_valid first high at T+N+1. Maximum N=31, giving rsp_valid at T+32.
- DONE:
  - rsp_valid=1; rsp_res and rsp_err held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE. The next request is accepted no earlier than the following cycle; there is no accept in the same cycle as the response handshake.
  - ALU inputs return to 0.
- req_ready=0 in EXEC, SHIFT and DONE. req_* inputs are ignored outside IDLE.
- Bits of req_b above SHAMT_W are ignored for shifts. Sub uses the ALU's two's-complement result; overflow wraps and is not flagged.
- busy = (state != IDLE).
- alu_* are registered outputs; alu_res is sampled combinationally in the same cycle.

Decomposition:
- Shared package alu_pkg:
  - Function-code constants: FN_ADD=0, FN_SUB=1, FN_AND=2, FN_OR=3, FN_XOR=4, FN_NOT=5, FN_SLA=6, FN_SRA=7, FN_SRL=8, FN_MAX=8.
  - State enum {IDLE, EXEC, SHIFT, DONE}.
  - DATA_W and SHAMT_W defaults.
- No sub-module is needed: the FSM, count and acc sit in one module. The ALU is instantiated by the parent and connected through the alu_* ports.

Test Plan:
- Add:
  - Stimulus: func=0, a=5, b=7, accepted at T, rsp_ready=1.
  - Required: alu_func=0 during T+1; rsp_valid at T+2 with rsp_res=12, rsp_err=0; req_ready back to 1 at T+3.
- Multi-cycle sla:
  - Stimulus: func=6, a=1, b=5.
  - Required: alu_b=1 for cycles T+1..T+5; alu_a sequence 1,2,4,8,16; rsp_valid at T+6 with rsp_res=32.
- Sra with backpressure:
  - Stimulus: func=7, a=0x80000000, b=0x24 (shamt=4); rsp_ready held low for 3 cycles.
  - Required: rsp_res=0xF8000000; rsp_valid and rsp_res stable across the stall; req_ready stays 0 until the response handshake.
- Zero shift and illegal func:
  - Stimulus: func=8, a=0x1234, b=0x20 (shamt=0).
  - Required: rsp_valid at T+1 with rsp_res=0x1234.
  - Stimulus: func=9.
  - Required: rsp_valid at T+1 with rsp_res=0, rsp_err=1.
- Reset mid-shift:
  - Stimulus: func=8, a=0xFFFFFFFF, b=31; assert rst at T+10 for one cycle.
  - Required: next cycle state IDLE, busy=0, rsp_valid=0, alu_*=0, req_ready=1.
  - Then a fresh add 1+1 returns 2 at the normal latency.
- Back-to-back ops:
  - Stimulus: 3 queued requests (and, srl by 2, not) with rsp_ready=1.
  - Required: each accepted only in IDLE; results 0x0F0F&0x00FF=0x000F, 0x10>>2=0x4, not 0=0xFFFFFFFF, delivered in order.
